// File: rtl/mem_test.sv
// mem_test: scripted exerciser for a 4-line fully-associative, write-through
// cache in front of an 8x8 backing RAM. A fixed 8-entry script of reads and
// writes is replayed forever. The FSM spends one cycle per state.
// Optional feature: define MEM_TEST_WRITE_ALLOCATE_EN to allocate a cache line
// on a write miss. When it is left undefined, a write miss goes straight to RAM.
module mem_test (
  input  logic       clk,
  input  logic       clr,
  output logic [3:0] state,
  output logic [7:0] data_out,
  output logic       hit,
  output logic [1:0] cache_hit,
  output logic [1:0] cache_lru,
  output logic [7:0] target_addr,
  output logic [7:0] target_data,
  output logic       target_rw,
  output logic [7:0] cache_addr,
  output logic [7:0] cache_data,
  output logic [7:0] cache_addr_in,
  output logic [7:0] cache_data_in,
  output logic       cache_clr,
  output logic       cache_enab,
  output logic       cache_rw,
  output logic [7:0] addr0, addr1, addr2, addr3,
  output logic [7:0] data0, data1, data2, data3,
  output logic [1:0] access0, access1, access2, access3,
  output logic [7:0] ram0, ram1, ram2, ram3, ram4, ram5, ram6, ram7
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    LOOKUP  = 4'd2,
    HIT_RD  = 4'd3,
    HIT_WR  = 4'd4,
    MISS_RD = 4'd5,
    FILL    = 4'd6,
    MEM_WR  = 4'd7,
    UPDATE  = 4'd8,
    NEXT    = 4'd9
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  index_reg;
  logic [7:0]  target_addr_reg, target_data_reg;
  logic        target_rw_reg;
  logic        hit_reg;
  logic [1:0]  cache_hit_reg;
  logic [7:0]  data_out_reg;
  logic [7:0]  fill_data_reg;

  logic [7:0]  tag_reg  [4];
  logic [7:0]  line_reg [4];
  logic [3:0]  valid_reg;
  logic [1:0]  age_reg  [4];
  logic [7:0]  ram_reg  [8];

  logic        script_rw;
  logic [7:0]  script_addr, script_data;
  logic [3:0]  match;
  logic        any_match;
  logic [1:0]  hit_idx;
  logic [1:0]  lru_idx;
  logic [7:0]  fill_value;
  logic        touch_en;

  // Fixed operation script; reads carry no data.
  always_comb begin
    script_rw   = 1'b0;
    script_addr = 8'h00;
    script_data = 8'h00;
    case (index_reg)
      3'd0: begin script_rw = 1'b1; script_addr = 8'h01; script_data = 8'hE0; end
      3'd1: begin script_rw = 1'b1; script_addr = 8'h02; script_data = 8'hC0; end
      3'd2: script_addr = 8'h01;
      3'd3: script_addr = 8'h03;
      3'd4: script_addr = 8'h04;
      3'd5: script_addr = 8'h05;
      3'd6: begin script_rw = 1'b1; script_addr = 8'hAA; script_data = 8'hC0; end
      default: script_addr = 8'h02;
    endcase
  end

  // Per-line tag comparators (full address is the tag).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] && (tag_reg[gi] == target_addr_reg);
    end
  endgenerate

  // Lowest matching line wins should more than one ever match.
  always_comb begin
    any_match = 1'b0;
    hit_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (match[i]) begin
        any_match = 1'b1;
        hit_idx   = 2'(i);
      end
    end
  end

  // LRU line is whichever line currently has age 3.
  always_comb begin
    lru_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (age_reg[i] == 2'd3) lru_idx = 2'(i);
    end
  end

  // A read miss fills with the RAM word. A write-allocate miss fills with the write data.
  assign fill_value = target_rw_reg ? target_data_reg : fill_data_reg;

  // A write miss without allocation touches no line. Every other completed access does.
`ifdef MEM_TEST_WRITE_ALLOCATE_EN
  assign touch_en = (state_reg == UPDATE);
`else
  assign touch_en = (state_reg == UPDATE) && (!target_rw_reg || hit_reg);
`endif

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic and cache-port strobes.
  always_comb begin
    state_next    = IDLE;
    cache_enab    = 1'b0;
    cache_rw      = 1'b0;
    cache_addr_in = 8'h00;
    cache_data_in = 8'h00;
    case (state_reg)
      IDLE:    state_next = FETCH;
      FETCH:   state_next = LOOKUP;
      LOOKUP: begin
        cache_enab = 1'b1;
        if (any_match)          state_next = target_rw_reg ? HIT_WR : HIT_RD;
        else if (!target_rw_reg) state_next = MISS_RD;
        else begin
`ifdef MEM_TEST_WRITE_ALLOCATE_EN
          state_next = FILL;
`else
          state_next = MEM_WR;
`endif
        end
      end
      HIT_RD:  state_next = UPDATE;
      HIT_WR: begin
        cache_enab    = 1'b1;
        cache_rw      = 1'b1;
        cache_addr_in = target_addr_reg;
        cache_data_in = target_data_reg;
        state_next    = MEM_WR;
      end
      MISS_RD: state_next = FILL;
      FILL: begin
        cache_enab    = 1'b1;
        cache_rw      = 1'b1;
        cache_addr_in = target_addr_reg;
        cache_data_in = fill_value;
        state_next    = target_rw_reg ? MEM_WR : UPDATE;
      end
      MEM_WR:  state_next = UPDATE;
      UPDATE: begin
        cache_enab = 1'b1;
        state_next = NEXT;
      end
      NEXT:    state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Script sequencing, lookup result capture and read-result register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      index_reg       <= 3'd0;
      target_addr_reg <= 8'h00;
      target_data_reg <= 8'h00;
      target_rw_reg   <= 1'b0;
      hit_reg         <= 1'b0;
      cache_hit_reg   <= 2'd0;
      data_out_reg    <= 8'h00;
      fill_data_reg   <= 8'h00;
    end else begin
      case (state_reg)
        FETCH: begin
          target_addr_reg <= script_addr;
          target_data_reg <= script_data;
          target_rw_reg   <= script_rw;
        end
        LOOKUP: begin
          hit_reg       <= any_match;
          cache_hit_reg <= any_match ? hit_idx : lru_idx;
        end
        MISS_RD: fill_data_reg <= ram_reg[target_addr_reg[2:0]];
        UPDATE:  if (!target_rw_reg) data_out_reg <= line_reg[cache_hit_reg];
        NEXT:    index_reg <= index_reg + 3'd1;
        default: ;
      endcase
    end
  end

  // Cache line storage, LRU ages and backing RAM.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      valid_reg <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        tag_reg[i]  <= 8'h00;
        line_reg[i] <= 8'h00;
        age_reg[i]  <= 2'(i);
      end
      for (int i = 0; i < 8; i++) ram_reg[i] <= 8'(i * 17);
    end else begin
      if (state_reg == HIT_WR) line_reg[cache_hit_reg] <= target_data_reg;
      if (state_reg == FILL) begin
        tag_reg[lru_idx]   <= target_addr_reg;
        line_reg[lru_idx]  <= fill_value;
        valid_reg[lru_idx] <= 1'b1;
      end
      if (state_reg == MEM_WR) ram_reg[target_addr_reg[2:0]] <= target_data_reg;
      if (touch_en) begin
        for (int i = 0; i < 4; i++) begin
          if (2'(i) == cache_hit_reg)                 age_reg[i] <= 2'd0;
          else if (age_reg[i] < age_reg[cache_hit_reg]) age_reg[i] <= age_reg[i] + 2'd1;
        end
      end
    end
  end

  assign state       = state_reg;
  assign data_out    = data_out_reg;
  assign hit         = hit_reg;
  assign cache_hit   = cache_hit_reg;
  assign cache_lru   = lru_idx;
  assign target_addr = target_addr_reg;
  assign target_data = target_data_reg;
  assign target_rw   = target_rw_reg;
  assign cache_addr  = target_addr_reg;
  assign cache_data  = line_reg[cache_hit_reg];
  assign cache_clr   = clr && (state_reg != IDLE);

  assign addr0 = tag_reg[0];  assign addr1 = tag_reg[1];
  assign addr2 = tag_reg[2];  assign addr3 = tag_reg[3];
  assign data0 = line_reg[0]; assign data1 = line_reg[1];
  assign data2 = line_reg[2]; assign data3 = line_reg[3];
  assign access0 = age_reg[0]; assign access1 = age_reg[1];
  assign access2 = age_reg[2]; assign access3 = age_reg[3];
  assign ram0 = ram_reg[0]; assign ram1 = ram_reg[1];
  assign ram2 = ram_reg[2]; assign ram3 = ram_reg[3];
  assign ram4 = ram_reg[4]; assign ram5 = ram_reg[5];
  assign ram6 = ram_reg[6]; assign ram7 = ram_reg[7];

endmodule

// File: tb/tb_mem_test.sv
// tb_mem_test: replays the mem_test script against a behavioural model.
// The model keeps a recency-ordered list of lines rather than ages. Random
// reset points and step counts exercise abort and restart behaviour.
`timescale 1ns/1ps
module tb_mem_test;
  logic clk = 1'b0;
  logic clr = 1'b0;

  logic [3:0] state;
  logic [7:0] data_out, target_addr, target_data;
  logic       hit, target_rw;
  logic [1:0] cache_hit, cache_lru;
  logic [7:0] cache_addr, cache_data, cache_addr_in, cache_data_in;
  logic       cache_clr, cache_enab, cache_rw;
  logic [7:0] addr0, addr1, addr2, addr3, data0, data1, data2, data3;
  logic [1:0] access0, access1, access2, access3;
  logic [7:0] ram0, ram1, ram2, ram3, ram4, ram5, ram6, ram7;

  logic [7:0] rams [8];
  logic [7:0] tags [4];
  logic [7:0] dats [4];
  logic [1:0] accs [4];
  assign rams[0] = ram0; assign rams[1] = ram1; assign rams[2] = ram2; assign rams[3] = ram3;
  assign rams[4] = ram4; assign rams[5] = ram5; assign rams[6] = ram6; assign rams[7] = ram7;
  assign tags[0] = addr0; assign tags[1] = addr1; assign tags[2] = addr2; assign tags[3] = addr3;
  assign dats[0] = data0; assign dats[1] = data1; assign dats[2] = data2; assign dats[3] = data3;
  assign accs[0] = access0; assign accs[1] = access1; assign accs[2] = access2; assign accs[3] = access3;

  mem_test dut (
    .clk(clk), .clr(clr), .state(state), .data_out(data_out), .hit(hit),
    .cache_hit(cache_hit), .cache_lru(cache_lru),
    .target_addr(target_addr), .target_data(target_data), .target_rw(target_rw),
    .cache_addr(cache_addr), .cache_data(cache_data),
    .cache_addr_in(cache_addr_in), .cache_data_in(cache_data_in),
    .cache_clr(cache_clr), .cache_enab(cache_enab), .cache_rw(cache_rw),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .access0(access0), .access1(access1), .access2(access2), .access3(access3),
    .ram0(ram0), .ram1(ram1), .ram2(ram2), .ram3(ram3),
    .ram4(ram4), .ram5(ram5), .ram6(ram6), .ram7(ram7)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Script as written in the requirements.
  bit         s_rw   [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] s_addr [8] = '{8'h01, 8'h02, 8'h01, 8'h03, 8'h04, 8'h05, 8'hAA, 8'h02};
  logic [7:0] s_data [8] = '{8'hE0, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'h00};

  // Behavioural model.
  logic [7:0] m_tag [4];
  logic [7:0] m_data [4];
  logic [7:0] m_ram [8];
  bit         m_valid [4];
  int         m_rec [$];     // front = most recently used
  logic [7:0] m_dout;
  logic       m_hit;
  logic [1:0] m_chit;
  int         m_step;
  int         exp_path [$];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_ram[i] = 8'(i * 17);
    for (int i = 0; i < 4; i++) begin
      m_tag[i] = 8'h00; m_data[i] = 8'h00; m_valid[i] = 1'b0;
    end
    m_rec.delete();
    for (int i = 0; i < 4; i++) m_rec.push_back(i);
    m_dout = 8'h00; m_hit = 1'b0; m_chit = 2'd0; m_step = 0;
  endtask

  function automatic int model_age(int line);
    for (int p = 0; p < m_rec.size(); p++) if (m_rec[p] == line) return p;
    return -1;
  endfunction

  task automatic model_touch(int line);
    for (int p = 0; p < m_rec.size(); p++) begin
      if (m_rec[p] == line) begin
        m_rec.delete(p);
        break;
      end
    end
    m_rec.push_front(line);
  endtask

  task automatic model_step();
    int op;
    int line;
    logic [7:0] a;
    logic [7:0] d;
    bit w;
    op = m_step % 8;
    a = s_addr[op]; d = s_data[op]; w = s_rw[op];
    line = -1;
    for (int i = 3; i >= 0; i--) if (m_valid[i] && m_tag[i] == a) line = i;
    exp_path.delete();
    exp_path.push_back(1); exp_path.push_back(2);
    m_hit  = (line >= 0);
    m_chit = m_hit ? 2'(line) : 2'(m_rec[3]);
    if (!w) begin
      if (m_hit) exp_path.push_back(3);
      else begin
        exp_path.push_back(5); exp_path.push_back(6);
        m_tag[m_chit] = a; m_data[m_chit] = m_ram[a[2:0]]; m_valid[m_chit] = 1'b1;
      end
      m_dout = m_data[m_chit];
      model_touch(int'(m_chit));
    end else begin
      if (m_hit) begin
        exp_path.push_back(4);
        m_data[m_chit] = d;
        model_touch(int'(m_chit));
      end else begin
`ifdef MEM_TEST_WRITE_ALLOCATE_EN
        exp_path.push_back(6);
        m_tag[m_chit] = a; m_data[m_chit] = d; m_valid[m_chit] = 1'b1;
        model_touch(int'(m_chit));
`endif
      end
      exp_path.push_back(7);
      m_ram[a[2:0]] = d;
    end
    exp_path.push_back(8); exp_path.push_back(9);
    m_step++;
  endtask

  // Checks every reset-forced value, sampled while clr is low.
  task automatic check_reset_values(string tag);
    total++; if (state !== 4'd0) begin bad++; $display("FAIL %s state got=%0d want=0", tag, state); end
    total++; if ({hit, cache_hit, data_out} !== 11'd0) begin bad++; $display("FAIL %s hit/cache_hit/data_out got=%0h want=0", tag, {hit, cache_hit, data_out}); end
    total++; if ({target_addr, target_data, target_rw} !== 17'd0) begin bad++; $display("FAIL %s target got=%0h want=0", tag, {target_addr, target_data, target_rw}); end
    total++; if ({cache_addr_in, cache_data_in} !== 16'd0) begin bad++; $display("FAIL %s cache_in got=%0h want=0", tag, {cache_addr_in, cache_data_in}); end
    total++; if (cache_clr !== 1'b0) begin bad++; $display("FAIL %s cache_clr got=%b want=0", tag, cache_clr); end
    for (int i = 0; i < 8; i++) begin
      total++; if (rams[i] !== 8'(i * 17)) begin bad++; $display("FAIL %s ram%0d got=%h want=%h", tag, i, rams[i], 8'(i * 17)); end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if ({tags[i], dats[i]} !== 16'd0 || accs[i] !== 2'(i)) begin
        bad++; $display("FAIL %s line%0d tag=%h data=%h age=%0d want 00/00/%0d", tag, i, tags[i], dats[i], accs[i], i);
      end
    end
    $display("reset check %s done", tag);
  endtask

  // Releases reset at a falling edge. Expects IDLE first, then FETCH at the next edge.
  task automatic release_reset();
    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1;
    total++; if (state !== 4'd0 || cache_clr !== 1'b0) begin bad++; $display("FAIL release_idle state=%0d cache_clr=%b want 0/0", state, cache_clr); end
    @(posedge clk); #1;
    total++; if (state !== 4'd1 || cache_clr !== 1'b1) begin bad++; $display("FAIL release_fetch state=%0d cache_clr=%b want 1/1", state, cache_clr); end
    model_reset();
  endtask

  // Runs one script step from FETCH to NEXT and compares with the model.
  task automatic run_step();
    int seen [$];
    bit path_ok;
    int op;
    op = m_step % 8;
    total++; if (state !== 4'd1) begin bad++; $display("FAIL step_start step=%0d state=%0d want=1", m_step, state); end
    model_step();
    seen.push_back(int'(state));
    for (int n = 0; n < 20 && state !== 4'd9; n++) begin
      @(posedge clk); #1;
      seen.push_back(int'(state));
      total++; if (accs[cache_lru] !== 2'd3) begin bad++; $display("FAIL lru_track cache_lru=%0d age=%0d want age 3", cache_lru, accs[cache_lru]); end
      total++; if (cache_enab !== (state inside {4'd2, 4'd4, 4'd6, 4'd8}) || cache_rw !== (state inside {4'd4, 4'd6})) begin
        bad++; $display("FAIL strobes state=%0d enab=%b rw=%b", state, cache_enab, cache_rw);
      end
    end
    path_ok = (seen.size() == exp_path.size());
    if (path_ok) for (int i = 0; i < seen.size(); i++) if (seen[i] != exp_path[i]) path_ok = 1'b0;
    total++; if (!path_ok) begin bad++; $display("FAIL path step=%0d got_len=%0d want_len=%0d last=%0d", m_step - 1, seen.size(), exp_path.size(), seen[seen.size()-1]); end
    total++; if ({target_rw, target_addr, target_data} !== {s_rw[op], s_addr[op], s_data[op]}) begin
      bad++; $display("FAIL target step=%0d got=%b/%h/%h want=%b/%h/%h", m_step - 1, target_rw, target_addr, target_data, s_rw[op], s_addr[op], s_data[op]);
    end
    total++; if (hit !== m_hit || cache_hit !== m_chit) begin bad++; $display("FAIL lookup step=%0d hit=%b line=%0d want=%b/%0d", m_step - 1, hit, cache_hit, m_hit, m_chit); end
    total++; if (data_out !== m_dout) begin bad++; $display("FAIL data_out step=%0d got=%h want=%h", m_step - 1, data_out, m_dout); end
    total++; if (cache_lru !== 2'(m_rec[3])) begin bad++; $display("FAIL cache_lru step=%0d got=%0d want=%0d", m_step - 1, cache_lru, m_rec[3]); end
    for (int i = 0; i < 8; i++) begin
      total++; if (rams[i] !== m_ram[i]) begin bad++; $display("FAIL ram%0d step=%0d got=%h want=%h", i, m_step - 1, rams[i], m_ram[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (tags[i] !== m_tag[i] || dats[i] !== m_data[i] || int'(accs[i]) != model_age(i)) begin
        bad++; $display("FAIL line%0d step=%0d got=%h/%h/%0d want=%h/%h/%0d", i, m_step - 1, tags[i], dats[i], accs[i], m_tag[i], m_data[i], model_age(i));
      end
    end
    $display("step %0d op=%0d rw=%b addr=%h hit=%b line=%0d dout=%h", m_step - 1, op, target_rw, target_addr, hit, cache_hit, data_out);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("power_on");
    release_reset();
  endtask

  task automatic test_script();
    for (int s = 0; s < 8; s++) run_step();
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 12; s++) run_step();
  endtask

  task automatic test_reset_mid_memwr();
    clr = 1'b0; #1;
    check_reset_values("pre_memwr");
    release_reset();
    for (int n = 0; n < 20 && state !== 4'd7; n++) begin @(posedge clk); #1; end
    total++; if (state !== 4'd7) begin bad++; $display("FAIL reach_memwr state=%0d want=7", state); end
    #2;
    clr = 1'b0;
    #1;
    check_reset_values("mid_memwr");
    @(posedge clk); #1;
    check_reset_values("mid_memwr_held");
    release_reset();
  endtask

  task automatic test_random_reset();
    for (int r = 0; r < 4; r++) begin
      int steps;
      int extra;
      steps = $urandom_range(0, 9);
      extra = $urandom_range(0, 5);
      for (int s = 0; s < steps; s++) run_step();
      repeat (extra) @(posedge clk);
      #($urandom_range(0, 3));
      clr = 1'b0;
      #1;
      check_reset_values("random");
      release_reset();
      for (int s = 0; s < 3; s++) run_step();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_script();
    test_back_to_back();
    test_reset_mid_memwr();
    test_random_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_test.md
MEM_TEST -- requirements
Module: mem_test

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; clr in 1, reset, asynchronous, active-low.
REQ-002 SHALL have outputs: state 4, FSM state; data_out 8, last read result; hit 1, last lookup hit; cache_hit 2, matched/victim line index; cache_lru 2, current LRU line.
REQ-003 SHALL have outputs: target_addr 8, target_data 8, target_rw 1 (1=write), current script operation.
REQ-004 SHALL have outputs: cache_addr 8, cache_data 8, lookup address and line data read; cache_addr_in 8, cache_data_in 8, tag/data written into a line; cache_clr 1 (active-low array clear); cache_enab 1; cache_rw 1 (1=write).
REQ-005 SHALL have outputs: addr0..addr3 8, data0..data3 8, access0..access3 2, cache line tag/data/age; ram0..ram7 8, backing RAM words.

Function
REQ-006 SHALL contain a 4-line fully-associative cache (8-bit tag = full address, 8-bit data, valid bit, 2-bit age per line) and an 8x8 backing RAM indexed by addr[2:0].
REQ-007 SHALL run a fixed 8-entry script, index 3 bits, wrapping 7->0: W 01<-E0; W 02<-C0; R 01; R 03; R 04; R 05; W AA<-C0; R 02.
REQ-008 FSM encoding: IDLE=0, FETCH=1, LOOKUP=2, HIT_RD=3, HIT_WR=4, MISS_RD=5, FILL=6, MEM_WR=7, UPDATE=8, NEXT=9; one cycle per state; codes 10-15 go to IDLE.
REQ-009 Transitions: IDLE->FETCH; FETCH->LOOKUP; LOOKUP->HIT_RD (read hit) / HIT_WR (write hit) / MISS_RD (read miss) / MEM_WR (write miss); HIT_RD->UPDATE; HIT_WR->MEM_WR; MISS_RD->FILL; FILL->UPDATE; MEM_WR->UPDATE; UPDATE->NEXT; NEXT->FETCH.
REQ-010 FETCH SHALL load target_addr/target_data/target_rw from script; NEXT SHALL increment index.
REQ-011 LOOKUP SHALL compare target_addr against all valid tags; hit and cache_hit registered at end of LOOKUP, held until next LOOKUP; on miss cache_hit = cache_lru.
REQ-012 Write policy write-through: MEM_WR writes target_data to ram[target_addr[2:0]]; HIT_WR writes target_data into the hit line.
REQ-013 MISS_RD SHALL read ram[target_addr[2:0]]; FILL SHALL write tag=target_addr, that data, valid=1 into line cache_lru.
REQ-014 UPDATE SHALL set data_out to line data on reads (unchanged on writes) and apply LRU: lines with age < age of touched line increment, touched line age=0; a write miss touches no line.
REQ-015 cache_lru SHALL be combinational: index of line with age 3; ages always a permutation of 0..3.
REQ-016 cache_enab=1 in LOOKUP, HIT_WR, FILL, UPDATE; cache_rw=1 in HIT_WR, FILL; cache_addr=target_addr; cache_data=data of cache_hit line; cache_addr_in/cache_data_in = tag/data being written, else 0.
REQ-017 Simultaneous hit on multiple lines impossible by construction; lowest index wins if it occurs.

Reset
REQ-018 clr=0 SHALL asynchronously force: state=IDLE, index=0, all target_*/cache_addr_in/cache_data_in/data_out=0, hit=0, cache_hit=0, all tags/data=0, valid=0, accessN=N, ramN=N*8'h11.
REQ-019 cache_clr SHALL be 0 while clr=0 and during IDLE, else 1; reset mid-operation aborts with no partial RAM write.

Configuration
REQ-020 Macro MEM_TEST_WRITE_ALLOCATE_EN: defined -> write miss goes LOOKUP->FILL (line filled with target_data, touched by LRU) then MEM_WR->UPDATE; undefined -> write-no-allocate per REQ-009.

Verification
REQ-021 Reset release -> state 0 then 1; ram0..7 = 00,11,..,77; access0..3 = 0,1,2,3.
REQ-022 Script steps 0-1 (no-allocate) -> hit=0, ram1=E0, ram2=C0, cache lines unchanged.
REQ-023 Step 2 R 01 -> miss, FILL line 3, data_out=E0, access3=0, others incremented.
REQ-024 Steps 3-5 -> lines filled with 33, 44, 55 tags 03/04/05; step 5 evicts oldest line; cache_lru tracks age-3 line every cycle.
REQ-025 Step 6 W AA<-C0 -> ram2=C0 via alias; step 7 R 02 -> data_out=C0; second pass R 01 -> hit=1 if not evicted.
REQ-026 Assert clr=0 during MEM_WR -> immediate state 0, RAM restored to reset values.
